bt_status_tx: RTL

BT_STATUS_TX -- requirements
Module: bt_status_tx

---
 rtl/bt_pkg.sv | 52 +++++
 rtl/bt_status_tx_if.sv | 22 ++
 rtl/uart_tx_byte.sv | 95 +++++++++
 rtl/bt_status_tx.sv | 88 ++++++++
 4 files changed

// File: rtl/bt_pkg.sv
// Shared definitions for the bluetooth status link: frame layout, serializer
// state encoding and the command codes understood by the companion receiver.
package bt_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [7:0] {
        CMD_PLAY   = 8'h01,
        CMD_PAUSE  = 8'h02,
        CMD_NEXT   = 8'h03,
        CMD_PREV   = 8'h04,
        CMD_VOL_UP = 8'h05,
        CMD_VOL_DN = 8'h06
    } bt_cmd_e;

    typedef struct packed {
        logic [2:0] song;
        logic [3:0] vol;
        logic       pause;
        logic [7:0] minute;
        logic [7:0] second;
    } status_t;

    // Byte idx of a status frame; byte 6 is the XOR of payload bytes 1..5.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input status_t s);
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        b1 = {5'b0, s.song};
        b2 = {4'b0, s.vol};
        b3 = {7'b0, s.pause};
        case (idx)
            3'd0:    frame_byte = FRAME_HDR;
            3'd1:    frame_byte = b1;
            3'd2:    frame_byte = b2;
            3'd3:    frame_byte = b3;
            3'd4:    frame_byte = s.minute;
            3'd5:    frame_byte = s.second;
            3'd6:    frame_byte = b1 ^ b2 ^ b3 ^ s.minute ^ s.second;
            default: frame_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/bt_status_tx_if.sv
// Status inputs and UART/handshake outputs of the bluetooth status transmitter.
interface bt_status_tx_if;
    logic       i_send;
    logic [2:0] i_song_select;
    logic [3:0] i_vol_level;
    logic       i_pause;
    logic [7:0] i_minute;
    logic [7:0] i_second;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_send, i_song_select, i_vol_level, i_pause, i_minute, i_second,
        input  o_tx, o_busy, o_done
    );

    modport slave (
        input  i_send, i_song_select, i_vol_level, i_pause, i_minute, i_second,
        output o_tx, o_busy, o_done
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A load taken in IDLE, or in the final stop-bit cycle,
// drives the start bit on the next edge so bytes chain with no idle gap.
module uart_tx_byte
    import bt_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       last
);

    localparam int             CW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(BAUD_DIV - 1);

    tx_state_e   state;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        tick;

    assign tick  = (cnt == CNT_MAX);
    assign ready = (state == IDLE);
    assign last  = (state == STOP) && tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= START;
                        cnt   <= '0;
                        shreg <= data;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        cnt     <= '0;
                        state   <= DATA;
                        bit_idx <= 3'd0;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt <= '0;
                        if (load) begin
                            state <= START;
                            shreg <= data;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/bt_status_tx.sv
// Bluetooth status frame transmitter: snapshots player status, frames it as
// A5 + 5 payload bytes + XOR checksum and streams it through uart_tx_byte.
module bt_status_tx
    import bt_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic          clk,
    input  logic          rst_n,
    bt_status_tx_if.slave bus
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;

    status_t    snap;
    logic [2:0] byte_idx;
    logic       busy;
    logic       done;
    logic       pending;

    logic       ser_tx;
    logic       ser_ready;
    logic       ser_last;
    logic       start;
    logic       frame_end;
    logic       load;
    logic [7:0] load_data;

    // The header goes out straight from the trigger edge; later bytes come
    // from the snapshot taken on that same edge.
    assign start     = ser_ready && !busy && (bus.i_send || pending);
    assign frame_end = ser_last && (byte_idx == 3'(FRAME_LEN - 1));
    assign load      = start || (ser_last && !frame_end);

    always_comb begin
        load_data = FRAME_HDR;
        if (!start)
            load_data = frame_byte(byte_idx + 3'd1, snap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap     <= '0;
            byte_idx <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pending  <= 1'b0;
        end else begin
            done <= frame_end;
            if (start) begin
                busy     <= 1'b1;
                byte_idx <= 3'd0;
                pending  <= 1'b0;
                snap     <= '{song:   bus.i_song_select,
                              vol:    bus.i_vol_level,
                              pause:  bus.i_pause,
                              minute: bus.i_minute,
                              second: bus.i_second};
            end else begin
                if (ser_last && !frame_end)
                    byte_idx <= byte_idx + 3'd1;
                if (frame_end)
                    busy <= 1'b0;
                // Requests during a frame collapse into one flag.
                if (bus.i_send && busy)
                    pending <= 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .data  (load_data),
        .tx    (ser_tx),
        .ready (ser_ready),
        .last  (ser_last)
    );

    assign bus.o_tx   = ser_tx;
    assign bus.o_busy = busy;
    assign bus.o_done = done;

endmodule
